// File: rtl/tx_fh_pkg.sv
// rtl/tx_fh_pkg.sv - shared encodings for the transmit frequency-hop sequencer
package tx_fh_pkg;

  typedef enum logic [1:0] {
    FH_FIXED = 2'd0,
    FH_ONCE  = 2'd1,
    FH_WRAP  = 2'd2
  } fh_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2
  } fh_state_e;

  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/tx_fh_idx.sv
// rtl/tx_fh_idx.sv - hop index generator (once/wrap/fixed) and table address adder
module tx_fh_idx
  import tx_fh_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TODH_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample,
  input  logic [1:0]        mode,
  input  logic [TODH_W-1:0] fh_num,
  input  logic [TODH_W-1:0] tod_h,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] fixed_addr,
  output logic [TODH_W-1:0] idx,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              once_end
);

  logic [TODH_W-1:0] cnt_q, cnt_d, cnt_next;

  always_comb begin
    cnt_next = '0;
    if (tod_h != '0 && fh_num != '0 && cnt_q < fh_num - TODH_W'(1)) begin
      cnt_next = cnt_q + TODH_W'(1);
    end

    idx      = '0;
    addr     = fixed_addr;
    valid    = 1'b1;
    once_end = 1'b0;
    case (mode)
      FH_ONCE: begin
        idx      = tod_h;
        valid    = (tod_h < fh_num);
        once_end = (tod_h >= fh_num);
        addr     = base_addr + ADDR_W'(tod_h);
      end
      FH_WRAP: begin
        idx   = cnt_next;
        valid = (fh_num != '0);
        addr  = base_addr + ADDR_W'(cnt_next);
      end
      default: ;
    endcase

    // The wrap counter only advances on the hop's read slot in wrap mode.
    cnt_d = cnt_q;
    if (sample && mode == FH_WRAP) begin
      cnt_d = cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_fh_seq.sv
// rtl/tx_fh_seq.sv - per-hop table fetch, frequency word load and load-enable window
module tx_fh_seq
  import tx_fh_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int FREQ_W    = 32,
  parameter int TODH_W    = 21,
  parameter int TODL_W    = 11,
  parameter int RAM_LAT   = 1,
  parameter int RD_SLOT   = 4,
  parameter int LOAD_SLOT = 12,
  parameter int EN_START  = 16,
  parameter int EN_STOP   = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_mode,
  input  logic              end_zero,
  input  logic [TODH_W-1:0] fh_num,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] fixed_addr,
  input  logic [TODH_W-1:0] tod_h,
  input  logic [TODL_W-1:0] tod_l,
  output logic [ADDR_W-1:0] freq_ram_addr,
  output logic              freq_ram_rd,
  input  logic [FREQ_W-1:0] freq_ram_data,
  output logic [FREQ_W-1:0] freq_factor,
  output logic              freq_en,
  output logic [TODH_W-1:0] hop_idx,
  output logic              pat_done
);

  fh_state_e             state_q, state_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [FREQ_W-1:0]     pending_q, pending_d;
  logic [TODH_W-1:0]     idx_hold_q, idx_hold_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [FREQ_W-1:0]     factor_q, factor_d;
  logic                  en_q, en_d;
  logic [TODH_W-1:0]     hop_idx_q, hop_idx_d;
  logic                  pat_done_q, pat_done_d;
  logic                  zero_sent_q, zero_sent_d;

  logic                  slot_rd, is_once, idx_valid, once_end;
  logic [TODH_W-1:0]     idx;
  logic [ADDR_W-1:0]     idx_addr;

  assign slot_rd = (tod_l == TODL_W'(RD_SLOT));
  assign is_once = (cfg_mode == FH_ONCE);

  tx_fh_idx #(
    .ADDR_W (ADDR_W),
    .TODH_W (TODH_W)
  ) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (slot_rd),
    .mode       (cfg_mode),
    .fh_num     (fh_num),
    .tod_h      (tod_h),
    .base_addr  (base_addr),
    .fixed_addr (fixed_addr),
    .idx        (idx),
    .addr       (idx_addr),
    .valid      (idx_valid),
    .once_end   (once_end)
  );

  // Output events are registered one tick early so they are visible on their named tod_l tick.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    pending_d   = pending_q;
    idx_hold_d  = idx_hold_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    factor_d    = factor_q;
    en_d        = en_q;
    hop_idx_d   = hop_idx_q;
    pat_done_d  = pat_done_q;
    zero_sent_d = zero_sent_q;

    if (slot_rd) begin
      // A read slot always starts a fresh hop, even if the previous one never finished.
      state_d = IDLE;
      en_d    = 1'b0;
      if (is_once) begin
        pat_done_d = once_end;
        if (!once_end) begin
          zero_sent_d = 1'b0;
        end
      end
      if (idx_valid) begin
        rd_d       = 1'b1;
        addr_d     = idx_addr;
        idx_hold_d = idx;
        lat_cnt_d  = '0;
        state_d    = WAIT;
      end else if (is_once && end_zero && !zero_sent_q && fh_num != '0) begin
        pending_d   = '0;
        idx_hold_d  = idx;
        zero_sent_d = 1'b1;
        state_d     = ARMED;
      end
    end else begin
      case (state_q)
        WAIT: begin
          lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
          if (lat_cnt_q == LAT_CNT_W'(RAM_LAT)) begin
            pending_d = freq_ram_data;
            state_d   = ARMED;
          end
        end
        ARMED: begin
          if (tod_l == TODL_W'(LOAD_SLOT - 1)) begin
            factor_d  = pending_q;
            hop_idx_d = idx_hold_q;
          end
          if (tod_l == TODL_W'(EN_START - 1)) begin
            en_d = 1'b1;
          end
          if (tod_l == TODL_W'(EN_STOP - 1)) begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      pending_q   <= '0;
      idx_hold_q  <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      factor_q    <= '0;
      en_q        <= 1'b0;
      hop_idx_q   <= '0;
      pat_done_q  <= 1'b0;
      zero_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      pending_q   <= pending_d;
      idx_hold_q  <= idx_hold_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      factor_q    <= factor_d;
      en_q        <= en_d;
      hop_idx_q   <= hop_idx_d;
      pat_done_q  <= pat_done_d;
      zero_sent_q <= zero_sent_d;
    end
  end

  assign freq_ram_addr = addr_q;
  assign freq_ram_rd   = rd_q;
  assign freq_factor   = factor_q;
  assign freq_en       = en_q;
  assign hop_idx       = hop_idx_q;
  assign pat_done      = pat_done_q;

endmodule
